// File: rtl/nucore_pkg.sv
// Shared NuCore definitions: sequencer state encoding, NOP instruction word, default PC width.
package nucore_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_STEP   = 2'b11
  } state_t;

  localparam int INSTR_W = 39;
  localparam logic [INSTR_W-1:0] NOP_WORD = '0;
  localparam int DEF_PCW = 6;

endpackage

// File: rtl/pipe_step_ctrl_edge_rise.sv
// Rising-edge pulse generator: pulse is combinational, high in the cycle the input first reads 1.
// The history flop clears on reset; no backpressure.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic pulse_o
);

  logic req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_i;
    end
  end

  assign pulse_o = req_i & ~req_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Run/step/halt sequencer for NuCore: Moore pipeline enables, drains IF_ID/ID_EX/ALUREG before halting.
// Requests act on the clock edge after they rise; no backpressure, pulses seen during DRAIN are dropped.
module pipe_step_ctrl
  import nucore_pkg::*;
#(
  parameter int PCW       = DEF_PCW,
  parameter int DRAIN_CYC = 3,
  parameter int CNTW      = 16,
  parameter bit START_RUN = 1'b0
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            run_req,
  input  logic            step_req,
  input  logic            halt_req,
  input  logic            bp_en,
  input  logic [PCW-1:0]  bp_addr,
  input  logic [PCW-1:0]  pc,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            alureg_en,
  output logic            ifid_bubble,
  output logic [1:0]      state,
  output logic            halted,
  output logic            step_done,
  output logic [CNTW-1:0] fetch_cnt
);

  if (DRAIN_CYC < 1) begin : g_bad_drain
    $error("pipe_step_ctrl: DRAIN_CYC must be >= 1");
  end

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYC - 1);
  localparam state_t RST_STATE = START_RUN ? ST_RUN : ST_HALTED;

  state_t          state_q;
  logic [DCW-1:0]  drain_q;
  logic [CNTW-1:0] fetch_q;
  logic            done_q;
  logic            run_p, step_p, halt_p;
  logic            bp_hit;

  edge_rise u_run_edge  (.clk(Clk), .rst_n(Rst), .req_i(run_req),  .pulse_o(run_p));
  edge_rise u_step_edge (.clk(Clk), .rst_n(Rst), .req_i(step_req), .pulse_o(step_p));
  edge_rise u_halt_edge (.clk(Clk), .rst_n(Rst), .req_i(halt_req), .pulse_o(halt_p));

  assign bp_hit = bp_en && (pc == bp_addr);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= RST_STATE;
      drain_q <= '0;
      fetch_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pc_en) begin
        fetch_q <= fetch_q + CNTW'(1);
      end
      case (state_q)
        ST_HALTED: begin
          // halt outranks step outranks run; a halt pulse just keeps us here
          if (!halt_p) begin
            if (step_p) begin
              state_q <= ST_STEP;
            end else if (run_p) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (halt_p || bp_hit) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        ST_STEP: begin
          state_q <= ST_DRAIN;
          drain_q <= DRAIN_LOAD;
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_HALTED;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        default: state_q <= RST_STATE;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    alureg_en   = 1'b0;
    ifid_bubble = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_HALTED: halted = 1'b1;
      ST_RUN, ST_STEP: begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        alureg_en = 1'b1;
      end
      ST_DRAIN: begin
        // fetch frozen; NOPs chase the in-flight instructions out to ALUREG
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        alureg_en   = 1'b1;
        ifid_bubble = 1'b1;
      end
      default: halted = 1'b0;
    endcase
  end

  assign state     = state_q;
  assign step_done = done_q;
  assign fetch_cnt = fetch_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl: two instances (CNTW=16 with breakpoint, CNTW=4 without) checked against an
// abstract run/step/drain model every cycle, plus directed literal expectations.
module tb_pipe_step_ctrl;

  localparam int DRAIN = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic bp_en = 1'b0;
  logic bp_en2 = 1'b0;
  logic [5:0] bp_addr = 6'd0;
  logic [5:0] pc1, pc2;
  logic [5:0] pc2_init = 6'd0;

  logic        d1_pc_en, d1_ifid_en, d1_idex_en, d1_alureg_en, d1_bub, d1_halted, d1_done;
  logic [1:0]  d1_state;
  logic [15:0] d1_fcnt;
  logic        d2_pc_en, d2_ifid_en, d2_idex_en, d2_alureg_en, d2_bub, d2_halted, d2_done;
  logic [1:0]  d2_state;
  logic [3:0]  d2_fcnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_step_ctrl #(.PCW(6), .DRAIN_CYC(DRAIN), .CNTW(16), .START_RUN(1'b0)) dut1 (
    .Clk(clk), .Rst(rst_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc1),
    .pc_en(d1_pc_en), .ifid_en(d1_ifid_en), .idex_en(d1_idex_en), .alureg_en(d1_alureg_en),
    .ifid_bubble(d1_bub), .state(d1_state), .halted(d1_halted), .step_done(d1_done),
    .fetch_cnt(d1_fcnt)
  );

  pipe_step_ctrl #(.PCW(6), .DRAIN_CYC(DRAIN), .CNTW(4), .START_RUN(1'b0)) dut2 (
    .Clk(clk), .Rst(rst_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .bp_en(bp_en2), .bp_addr(bp_addr), .pc(pc2),
    .pc_en(d2_pc_en), .ifid_en(d2_ifid_en), .idex_en(d2_idex_en), .alureg_en(d2_alureg_en),
    .ifid_bubble(d2_bub), .state(d2_state), .halted(d2_halted), .step_done(d2_done),
    .fetch_cnt(d2_fcnt)
  );

  // Program counters advance whenever the sequencer lets the core fetch.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc1 <= 6'd0;
      pc2 <= pc2_init;
    end else begin
      if (d1_pc_en) pc1 <= pc1 + 6'd1;
      if (d2_pc_en) pc2 <= pc2 + 6'd1;
    end
  end

  typedef struct {
    bit running;
    bit stepping;
    int drain_left;
    int fetches;
    bit done;
    bit pr, ps, ph;
  } mdl_t;

  function automatic mdl_t m_reset();
    mdl_t m;
    m.running = 0; m.stepping = 0; m.drain_left = 0; m.fetches = 0; m.done = 0;
    m.pr = 0; m.ps = 0; m.ph = 0;
    return m;
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit r, bit s, bit h, bit bpe, logic [5:0] bpa,
                                  logic [5:0] pc, int cntw);
    mdl_t n = m;
    bit rp = r && !m.pr;
    bit sp = s && !m.ps;
    bit hp = h && !m.ph;
    n.done = 0;
    if (m.running || m.stepping) n.fetches = (m.fetches + 1) % (1 << cntw);
    if (m.drain_left > 0) begin
      n.drain_left = m.drain_left - 1;
      if (n.drain_left == 0) n.done = 1;
    end else if (m.stepping) begin
      n.stepping = 0;
      n.drain_left = DRAIN;
    end else if (m.running) begin
      if (hp || (bpe && pc == bpa)) begin
        n.running = 0;
        n.drain_left = DRAIN;
      end
    end else if (!hp) begin
      if (sp) n.stepping = 1;
      else if (rp) n.running = 1;
    end
    n.pr = r; n.ps = s; n.ph = h;
    return n;
  endfunction

  mdl_t m1, m2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = m_reset();
      m2 = m_reset();
    end else begin
      m1 = m_next(m1, run_req, step_req, halt_req, bp_en,  bp_addr, pc1, 16);
      m2 = m_next(m2, run_req, step_req, halt_req, bp_en2, bp_addr, pc2, 4);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [1:0] st,
                         input logic pe, input logic ie, input logic de, input logic ae,
                         input logic bub, input logic hl, input logic sd, input logic [31:0] fc);
    logic [1:0] est;
    logic       efetch, ebub;
    efetch = m.running || m.stepping;
    ebub   = (m.drain_left > 0);
    est    = m.running ? 2'd1 : m.stepping ? 2'd3 : ebub ? 2'd2 : 2'd0;
    chk({tag, "_state"},  {30'd0, st}, {30'd0, est});
    chk({tag, "_pc_en"},  {31'd0, pe}, {31'd0, efetch});
    chk({tag, "_ifid"},   {31'd0, ie}, {31'd0, efetch || ebub});
    chk({tag, "_idex"},   {31'd0, de}, {31'd0, efetch || ebub});
    chk({tag, "_alureg"}, {31'd0, ae}, {31'd0, efetch || ebub});
    chk({tag, "_bubble"}, {31'd0, bub}, {31'd0, ebub});
    chk({tag, "_halted"}, {31'd0, hl}, {31'd0, (est == 2'd0)});
    chk({tag, "_done"},   {31'd0, sd}, {31'd0, m.done});
    chk({tag, "_fcnt"},   fc, m.fetches);
  endtask

  always @(negedge clk) begin
    cmp_dut("d1", m1, d1_state, d1_pc_en, d1_ifid_en, d1_idex_en, d1_alureg_en, d1_bub,
            d1_halted, d1_done, {16'd0, d1_fcnt});
    cmp_dut("d2", m2, d2_state, d2_pc_en, d2_ifid_en, d2_idex_en, d2_alureg_en, d2_bub,
            d2_halted, d2_done, {28'd0, d2_fcnt});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(3);
    chk("rst_state",  {30'd0, d1_state}, 32'd0);
    chk("rst_halted", {31'd0, d1_halted}, 32'd1);
    chk("rst_en", {28'd0, d1_pc_en, d1_ifid_en, d1_idex_en, d1_alureg_en}, 32'd0);
    rst_n = 1'b1;
    tick(10);
    chk("idle_fcnt",   {16'd0, d1_fcnt}, 32'd0);
    chk("idle_halted", {31'd0, d1_halted}, 32'd1);

    // single step: STEP 1 cycle, DRAIN 3 cycles, back to HALTED
    step_req = 1'b1;
    tick(1);
    chk("step_state", {30'd0, d1_state}, 32'd3);
    chk("step_pc_en", {31'd0, d1_pc_en}, 32'd1);
    step_req = 1'b0;
    tick(1);
    chk("step_drain1",  {30'd0, d1_state}, 32'd2);
    chk("step_bub1",    {31'd0, d1_bub}, 32'd1);
    chk("step_pcen_d1", {31'd0, d1_pc_en}, 32'd0);
    tick(2);
    chk("step_drain3", {30'd0, d1_state}, 32'd2);
    tick(1);
    chk("step_halted", {31'd0, d1_halted}, 32'd1);
    chk("step_done",   {31'd0, d1_done}, 32'd1);
    chk("step_fcnt",   {16'd0, d1_fcnt}, 32'd1);
    chk("step_bub0",   {31'd0, d1_bub}, 32'd0);
    tick(1);
    chk("step_done_clr", {31'd0, d1_done}, 32'd0);

    // breakpoint at pc 5 with pc starting from 0
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bp_en = 1'b1; bp_addr = 6'd5; run_req = 1'b1;
    tick(1);
    chk("bp_run",  {30'd0, d1_state}, 32'd1);
    chk("bp_pc0",  {26'd0, pc1}, 32'd0);
    tick(5);
    chk("bp_at5_state", {30'd0, d1_state}, 32'd1);
    chk("bp_at5_pc",    {26'd0, pc1}, 32'd5);
    tick(1);
    chk("bp_drain", {30'd0, d1_state}, 32'd2);
    chk("bp_fcnt",  {16'd0, d1_fcnt}, 32'd6);
    tick(3);
    chk("bp_halted", {31'd0, d1_halted}, 32'd1);
    chk("bp_fcnt_h", {16'd0, d1_fcnt}, 32'd6);
    chk("bp_done",   {31'd0, d1_done}, 32'd1);

    // resume from pc 6: breakpoint at 5 is behind us
    run_req = 1'b0;
    tick(1);
    run_req = 1'b1;
    tick(1);
    chk("resume_state", {30'd0, d1_state}, 32'd1);
    chk("resume_pc",    {26'd0, pc1}, 32'd6);
    tick(1);
    chk("resume_run2", {30'd0, d1_state}, 32'd1);
    chk("resume_fcnt", {16'd0, d1_fcnt}, 32'd7);

    // halt and step rising together while running: halt wins
    run_req = 1'b0; halt_req = 1'b1; step_req = 1'b1;
    tick(1);
    chk("hs_drain", {30'd0, d1_state}, 32'd2);
    tick(2);
    chk("hs_drain3", {30'd0, d1_state}, 32'd2);
    tick(1);
    chk("hs_halted", {31'd0, d1_halted}, 32'd1);
    chk("hs_done",   {31'd0, d1_done}, 32'd1);
    chk("hs_fcnt",   {16'd0, d1_fcnt}, 32'd8);
    halt_req = 1'b0; step_req = 1'b0;
    tick(1);

    // reset in the second drain cycle
    pc2_init = 6'd54;
    run_req = 1'b1;
    tick(1);
    run_req = 1'b0;
    tick(2);
    halt_req = 1'b1;
    tick(1);
    chk("rd_drain1", {30'd0, d1_state}, 32'd2);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_state", {30'd0, d1_state}, 32'd0);
    chk("rd_fcnt",  {16'd0, d1_fcnt}, 32'd0);
    chk("rd_done",  {31'd0, d1_done}, 32'd0);
    halt_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("rd_halted", {31'd0, d1_halted}, 32'd1);
    chk("rd_nodone", {31'd0, d1_done}, 32'd0);

    // 20 fetches: 4-bit counter wraps to 4, pc2 wraps 63->0
    bp_en = 1'b0;
    run_req = 1'b1;
    tick(1);
    chk("wrap_run", {30'd0, d2_state}, 32'd1);
    chk("wrap_pc0", {26'd0, pc2}, 32'd54);
    tick(20);
    chk("wrap_fcnt2", {28'd0, d2_fcnt}, 32'd4);
    chk("wrap_fcnt1", {16'd0, d1_fcnt}, 32'd20);
    chk("wrap_pc2",   {26'd0, pc2}, 32'd10);
    chk("wrap_state", {30'd0, d2_state}, 32'd1);
    run_req = 1'b0; halt_req = 1'b1;
    tick(4);
    chk("wrap_halted", {31'd0, d2_halted}, 32'd1);
    halt_req = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
